// File: rtl/capsense_pkg.sv
// Shared types and helpers for the capacitive-touch scanner.
package capsense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISCHARGE,
    MEASURE,
    UPDATE
  } cs_state_t;

  // Board packages test this to decide whether to build the scanner.
  localparam bit Capsense = 1'b1;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cs_bus_width(input int chans, input int width);
    return chans * width;
  endfunction

endpackage

// File: rtl/capsense_chan.sv
// One pad channel: rise-time counter with timeout, threshold/hysteresis compare and scan-count debounce.
// Counter advances every MEASURE cycle; count_q and touched load on the UPDATE cycle.
module capsense_chan
  import capsense_pkg::*;
#(
  parameter int CountWidth = 16,
  parameter int FilterLen  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  measure,
  input  logic                  update,
  input  logic                  pad_s,
  input  logic [CountWidth-1:0] threshold,
  input  logic [CountWidth-1:0] hysteresis,
  output logic                  stopped,
  output logic [CountWidth-1:0] count_q,
  output logic                  touched
);

  localparam logic [CountWidth-1:0] CntMax  = '1;
  localparam logic [3:0]            RunLast = 4'(FilterLen - 1);

  logic [CountWidth-1:0] cnt;
  logic [3:0]            run;
  logic [CountWidth:0]   release_wide;
  logic [CountWidth-1:0] release_lvl;
  logic                  cand;

  // Release level is computed one bit wider so a large hysteresis clamps to 0 instead of wrapping.
  always_comb begin
    release_wide = {1'b0, threshold} - {1'b0, hysteresis};
    release_lvl  = release_wide[CountWidth] ? '0 : release_wide[CountWidth-1:0];
    cand         = touched;
    if (cnt > threshold) begin
      cand = 1'b1;
    end else if (cnt < release_lvl) begin
      cand = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      stopped <= 1'b0;
      count_q <= '0;
      run     <= '0;
      touched <= 1'b0;
    end else begin
      if (start) begin
        cnt     <= '0;
        stopped <= 1'b0;
      end else if (measure && !stopped) begin
        if (pad_s || cnt == CntMax) begin
          stopped <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (update) begin
        count_q <= cnt;
        if (cand != touched) begin
          if (run == RunLast) begin
            touched <= ~touched;
            run     <= '0;
          end else begin
            run <= run + 1'b1;
          end
        end else begin
          run <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/capsense_scan.sv
// N-channel capacitive-touch scanner: discharge all pads, time each pad's rise, debounce into touched flags.
// Scan period DischargeCycles + max count + 3 clocks; no backpressure, results are posted with a scan_done pulse.
module capsense_scan
  import capsense_pkg::*;
#(
  parameter int NumSense        = 4,
  parameter int CountWidth      = 16,
  parameter int DischargeCycles = 64,
  parameter int FilterLen       = 3
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            enable,
  input  logic [CountWidth-1:0]                           threshold,
  input  logic [CountWidth-1:0]                           hysteresis,
  input  logic [NumSense-1:0]                             pad_in,
  output logic [NumSense-1:0]                             pad_oe,
  output logic [cs_bus_width(NumSense, CountWidth)-1:0]   count_o,
  output logic [NumSense-1:0]                             touched,
  output logic                                            scan_done,
  output logic                                            busy
);

  localparam int               TimerW    = cs_width(DischargeCycles);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(DischargeCycles - 1);

  cs_state_t           state, next_state;
  logic [TimerW-1:0]   timer;
  logic [NumSense-1:0] pad_meta, pad_s;
  logic [NumSense-1:0] stopped;
  logic                timer_done, all_stopped, start, measure, update;

  assign timer_done  = (timer == TimerLast);
  assign all_stopped = &stopped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_meta <= '0;
      pad_s    <= '0;
    end else begin
      pad_meta <= pad_in;
      pad_s    <= pad_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // enable is only looked at from IDLE and UPDATE, so dropping it never cuts a scan short.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    measure    = 1'b0;
    update     = 1'b0;
    case (state)
      IDLE:      if (enable) next_state = DISCHARGE;
      DISCHARGE: if (timer_done) begin
                   next_state = MEASURE;
                   start      = 1'b1;
                 end
      MEASURE:   begin
                   measure = 1'b1;
                   if (all_stopped) next_state = UPDATE;
                 end
      UPDATE:    begin
                   update     = 1'b1;
                   next_state = enable ? DISCHARGE : IDLE;
                 end
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      pad_oe    <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      timer     <= (state == DISCHARGE && !timer_done) ? timer + 1'b1 : '0;
      pad_oe    <= {NumSense{next_state == DISCHARGE}};
      busy      <= (next_state != IDLE);
      scan_done <= update;
    end
  end

  for (genvar i = 0; i < NumSense; i++) begin : g_chan
    capsense_chan #(
      .CountWidth(CountWidth),
      .FilterLen (FilterLen)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .measure   (measure),
      .update    (update),
      .pad_s     (pad_s[i]),
      .threshold (threshold),
      .hysteresis(hysteresis),
      .stopped   (stopped[i]),
      .count_q   (count_o[i*CountWidth +: CountWidth]),
      .touched   (touched[i])
    );
  end

endmodule
